// File: rtl/isp_loader_if.sv
// isp_loader_if: UART byte stream in, code-RAM write port and core reset out
interface isp_loader_if #(parameter int ADDR_W = 12);
    logic              ISPEN;
    logic [7:0]        RX_DATA;
    logic              RX_VALID;
    logic              WR;
    logic [ADDR_W-1:0] WRADDR;
    logic [31:0]       WRDATA;
    logic              CORE_RST_N;
    logic [ADDR_W:0]   WORD_CNT;
    logic              OVF;
    logic              TO_ERR;
    modport master (output ISPEN, RX_DATA, RX_VALID,
                    input WR, WRADDR, WRDATA, CORE_RST_N, WORD_CNT, OVF, TO_ERR);
    modport slave  (input ISPEN, RX_DATA, RX_VALID,
                    output WR, WRADDR, WRDATA, CORE_RST_N, WORD_CNT, OVF, TO_ERR);
endinterface

// File: rtl/isp_loader.sv
// isp_loader: assembles UART bytes into 32-bit code-RAM words and sequences the core reset
module isp_loader #(
    parameter int ADDR_W   = 12,
    parameter int TIMEOUT  = 50000,
    parameter int HOLD_CYC = 16
) (
    input logic         CLK,
    input logic         RESET,
    isp_loader_if.slave bus
);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, FLUSH = 3'd2, HOLD = 3'd3, RUN = 3'd4;
    logic [2:0]        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       asm_q, asm_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              wr_q, wr_d;
    logic [31:0]       wrdata_q, wrdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              to_q, to_d;
    logic              full;
    assign full = cnt_q[ADDR_W];
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        asm_d    = asm_q;
        idle_d   = '0;
        hold_d   = '0;
        wr_d     = 1'b0;
        wrdata_d = wrdata_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        to_d     = to_q;
        // address saturates at the top word so a full RAM never wraps back to 0
        if (wr_q) begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, ~&addr_q};
        end
        case (state_q)
            IDLE: state_d = bus.ISPEN ? LOAD : HOLD;
            LOAD: begin
                if (!bus.ISPEN) state_d = FLUSH;
                if (bus.RX_VALID && full) ovf_d = 1'b1;
                else if (bus.RX_VALID && lane_q == 2'd3) begin
                    wr_d     = 1'b1;
                    wrdata_d = {bus.RX_DATA, asm_q};
                    asm_d    = '0;
                    lane_d   = '0;
                end else if (bus.RX_VALID) begin
                    asm_d[{lane_q, 3'b000} +: 8] = bus.RX_DATA;
                    lane_d = lane_q + 1'b1;
                end else if (lane_q != 2'd0 && idle_q == IW'(TIMEOUT - 1)) begin
                    lane_d = '0;
                    asm_d  = '0;
                    to_d   = 1'b1;
                end else if (lane_q != 2'd0) idle_d = idle_q + 1'b1;
            end
            FLUSH: begin
                state_d  = HOLD;
                wr_d     = lane_q != 2'd0 && !full;
                wrdata_d = wr_d ? {8'h00, asm_q} : wrdata_q;
                lane_d   = '0;
                asm_d    = '0;
            end
            HOLD: begin
                state_d = bus.ISPEN ? LOAD : (hold_q == HW'(HOLD_CYC - 1) ? RUN : HOLD);
                hold_d  = hold_q + 1'b1;
            end
            RUN: state_d = bus.ISPEN ? LOAD : RUN;
            default: state_d = IDLE;
        endcase
        if (state_d == LOAD && state_q != LOAD) begin
            lane_d = '0;
            asm_d  = '0;
            addr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            to_d   = 1'b0;
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            lane_q   <= '0;
            asm_q    <= '0;
            idle_q   <= '0;
            hold_q   <= '0;
            wr_q     <= 1'b0;
            wrdata_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            idle_q   <= idle_d;
            hold_q   <= hold_d;
            wr_q     <= wr_d;
            wrdata_q <= wrdata_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
        end
    end
    assign bus.WR         = wr_q;
    assign bus.WRADDR     = addr_q;
    assign bus.WRDATA     = wrdata_q;
    assign bus.CORE_RST_N = state_q == RUN;
    assign bus.WORD_CNT   = cnt_q;
    assign bus.OVF        = ovf_q;
    assign bus.TO_ERR     = to_q;
endmodule

// File: tb/tb_isp_loader.sv
// tb_isp_loader: table of flush/full-word loads plus hand-written corner sequences, writes checked via scoreboard
module tb_isp_loader;
    localparam int AW = 2, TO = 20, HC = 4;
    typedef struct { logic [1:0] a; logic [31:0] d; } wr_t;
    typedef struct { int n; logic [31:0] b; logic [31:0] exp; } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_pass = 0, n_tot = 0;
    wr_t sb[$];
    wr_t mon_e;
    vec_t tbl[4];
    logic [31:0] w;
    isp_loader_if #(.ADDR_W(AW)) bus();
    isp_loader #(.ADDR_W(AW), .TIMEOUT(TO), .HOLD_CYC(HC)) dut (.CLK(clk), .RESET(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input logic [7:0] b);
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        tick();
        bus.RX_VALID = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.ISPEN = 1'b0;
        bus.RX_VALID = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask
    task automatic start_load();
        do_reset();
        bus.ISPEN = 1'b1;
        tick();
    endtask
    task automatic push(input logic [1:0] a, input logic [31:0] d);
        sb.push_back('{a, d});
    endtask
    always @(negedge clk) begin
        if (bus.WR === 1'b1) begin
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_wr: got addr %0d data %h expected no write", bus.WRADDR, bus.WRDATA);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(bus.WRADDR), 32'(mon_e.a));
                chk("wr_data", bus.WRDATA, mon_e.d);
            end
        end
    end
    initial begin
        tbl = '{'{1, 32'hffffff5a, 32'h0000005a}, '{2, 32'h99991234, 32'h00001234},
                '{3, 32'h88030201, 32'h00030201}, '{4, 32'hefbeadde, 32'hefbeadde}};
        bus.RX_DATA = 8'h00;
        do_reset();
        chk("rst_wr", 32'(bus.WR), 0);
        chk("rst_wraddr", 32'(bus.WRADDR), 0);
        chk("rst_wrdata", bus.WRDATA, 0);
        chk("rst_core_rst_n", 32'(bus.CORE_RST_N), 0);
        chk("rst_word_cnt", 32'(bus.WORD_CNT), 0);
        chk("rst_ovf", 32'(bus.OVF), 0);
        chk("rst_to_err", 32'(bus.TO_ERR), 0);
        // table: n bytes then ISPEN drop, one write with unfilled lanes zeroed
        for (int i = 0; i < 4; i++) begin
            start_load();
            push(2'd0, tbl[i].exp);
            for (int j = 0; j < tbl[i].n; j++) send(tbl[i].b[8*j +: 8]);
            bus.ISPEN = 1'b0;
            tick(HC + 3);
            chk("tbl_word_cnt", 32'(bus.WORD_CNT), 1);
            chk("tbl_wraddr", 32'(bus.WRADDR), 1);
            chk("tbl_sb_empty", sb.size(), 0);
        end
        // two back-to-back words, second starts in the WR cycle of the first
        start_load();
        push(2'd0, 32'h12345678);
        push(2'd1, 32'h04030201);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        tick(3);
        chk("b2b_word_cnt", 32'(bus.WORD_CNT), 2);
        chk("b2b_wraddr", 32'(bus.WRADDR), 2);
        // flush then exact hold length, then RUN ignores bytes and ISPEN re-enters LOAD
        start_load();
        push(2'd0, 32'h0000bbaa);
        send(8'haa); send(8'hbb);
        bus.ISPEN = 1'b0;
        tick();
        chk("flush_core_rst_n", 32'(bus.CORE_RST_N), 0);
        tick(HC);
        chk("hold_last_core_rst_n", 32'(bus.CORE_RST_N), 0);
        tick();
        chk("run_core_rst_n", 32'(bus.CORE_RST_N), 1);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        tick(2);
        chk("run_word_cnt", 32'(bus.WORD_CNT), 1);
        bus.ISPEN = 1'b1;
        tick();
        chk("reload_core_rst_n", 32'(bus.CORE_RST_N), 0);
        chk("reload_word_cnt", 32'(bus.WORD_CNT), 0);
        // timeout discards partial word exactly after TO idle cycles
        start_load();
        send(8'h11);
        tick(TO - 1);
        chk("to_err_before", 32'(bus.TO_ERR), 0);
        tick();
        chk("to_err_after", 32'(bus.TO_ERR), 1);
        push(2'd0, 32'h04030201);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        tick(2);
        chk("to_word_cnt", 32'(bus.WORD_CNT), 1);
        chk("to_err_sticky", 32'(bus.TO_ERR), 1);
        // overflow: 17 words into a 4-word RAM
        start_load();
        for (int i = 0; i < 17; i++) begin
            for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(8'h40 + i*4 + j);
            if (i < 4) push(2'(i), w);
            for (int j = 0; j < 4; j++) begin
                send(w[8*j +: 8]);
                if (i == 3 && j == 3) chk("ovf_not_yet", 32'(bus.OVF), 0);
            end
        end
        tick(2);
        chk("ovf_set", 32'(bus.OVF), 1);
        chk("ovf_word_cnt", 32'(bus.WORD_CNT), 4);
        chk("ovf_no_wrap", 32'(bus.WRADDR), 3);
        bus.ISPEN = 1'b0;
        tick(4);
        chk("ovf_sb_empty", sb.size(), 0);
        // reset mid-word discards the partial word
        start_load();
        push(2'd0, 32'hcafef00d);
        send(8'h0d); send(8'hf0); send(8'hfe); send(8'hca);
        send(8'h91); send(8'h92); send(8'h93);
        rst = 1'b1;
        tick();
        chk("mid_rst_wr", 32'(bus.WR), 0);
        chk("mid_rst_wrdata", bus.WRDATA, 0);
        chk("mid_rst_word_cnt", 32'(bus.WORD_CNT), 0);
        chk("mid_rst_core_rst_n", 32'(bus.CORE_RST_N), 0);
        rst = 1'b0;
        tick();
        push(2'd0, 32'hd4c3b2a1);
        send(8'ha1); send(8'hb2); send(8'hc3); send(8'hd4);
        tick(2);
        chk("post_rst_word_cnt", 32'(bus.WORD_CNT), 1);
        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
